sistema_de_ventilacao: RTL and testbench

// - Ventilation/pressure-cascade controller for the plant containment: samples seven 4-bit pressure sensors and drives six dampers.
// - Air must flow from clean zones (control room) towards contaminated zones (reactor, return tube).
// - Raises the audible ventilation alarm on a persistent cascade violation or on reactor over-pressure.
// - Sits between the sensor front-end and the damper actuators; all outputs are registered.

---
 rtl/sistema_de_ventilacao.sv | 127 ++++++++++++
 tb/tb_sistema_de_ventilacao.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sistema_de_ventilacao.sv
// Containment ventilation controller: drives the pressure-cascade dampers and
// raises the audible alarm on persistent cascade loss or reactor over-pressure.
module sistema_de_ventilacao #(
   parameter int unsigned PERSIST = 4,
   parameter int unsigned CLEAR   = 8,
   parameter logic [3:0]  REA_MAX = 4'hC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sensPresSC,
   input  logic [3:0] sensPresS1,
   input  logic [3:0] sensPresS2,
   input  logic [3:0] sensPresS3,
   input  logic [3:0] sensPresTubSR,
   input  logic [3:0] sensPresTubSS,
   input  logic [3:0] sensPresRea,
   output logic       alarmeSonoroVentilacao,
   output logic       damperS12,
   output logic       damperS23,
   output logic       damperS3SS,
   output logic       damperS3SR,
   output logic       damperSSSC,
   output logic       damperRSR
);

   typedef enum logic [1:0] {
      NORMAL,
      SUSPECT,
      ALARM,
      EMERGENCY
   } state_t;

   localparam int VW = $clog2(PERSIST + 1);
   localparam int CW = $clog2(CLEAR + 1);
   localparam logic [VW-1:0] PMAX = VW'(PERSIST);
   localparam logic [CW-1:0] CMAX = CW'(CLEAR);

   state_t          state_q, state_d;
   logic [VW-1:0]   viol_q, viol_d;
   logic [CW-1:0]   clr_q, clr_d;
   logic [5:0]      dmp_q, dmp_d;
   logic            alarm_q, alarm_d;
   logic            ok;
   logic            emerg;

   assign ok = (sensPresSC > sensPresS1) && (sensPresS1 > sensPresS2) &&
               (sensPresS2 > sensPresS3) && (sensPresS3 > sensPresRea) &&
               (sensPresRea > sensPresTubSR);
   assign emerg = (sensPresRea >= REA_MAX);

   always_comb begin
      state_d = state_q;
      viol_d  = viol_q;
      clr_d   = clr_q;
      if (emerg) begin
         state_d = EMERGENCY;
      end else begin
         unique case (state_q)
            NORMAL: begin
               if (!ok) begin
                  state_d = SUSPECT;
                  viol_d  = VW'(1);
               end
            end
            SUSPECT: begin
               if (ok) begin
                  state_d = NORMAL;
                  viol_d  = '0;
               end else begin
                  if (viol_q < PMAX) viol_d = viol_q + VW'(1);
                  if (viol_d == PMAX) begin
                     state_d = ALARM;
                     clr_d   = '0;
                  end
               end
            end
            ALARM: begin
               if (!ok) clr_d = '0;
               else if (clr_q < CMAX) clr_d = clr_q + CW'(1);
               if (clr_d == CMAX) begin
                  state_d = NORMAL;
                  clr_d   = '0;
                  viol_d  = '0;
               end
            end
            EMERGENCY: begin
               state_d = ALARM;
               clr_d   = '0;
            end
            default: state_d = NORMAL;
         endcase
      end
      alarm_d = (state_d == ALARM) || (state_d == EMERGENCY);
      // Over-pressure vents the reactor and S3 to the return tube, isolates the rest
      if (emerg) begin
         dmp_d = 6'b000101;
      end else begin
         dmp_d = {sensPresS1 > sensPresS2,
                  sensPresS2 > sensPresS3,
                  sensPresTubSS > sensPresS3,
                  sensPresS3 > sensPresTubSR,
                  sensPresTubSS > sensPresSC,
                  sensPresRea > sensPresTubSR};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NORMAL;
         viol_q  <= '0;
         clr_q   <= '0;
         dmp_q   <= '0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         viol_q  <= viol_d;
         clr_q   <= clr_d;
         dmp_q   <= dmp_d;
         alarm_q <= alarm_d;
      end
   end

   assign alarmeSonoroVentilacao = alarm_q;
   assign {damperS12, damperS23, damperS3SS,
           damperS3SR, damperSSSC, damperRSR} = dmp_q;

endmodule

// File: tb/tb_sistema_de_ventilacao.sv
// Directed bench for sistema_de_ventilacao: a behavioural model predicts each
// edge's outputs into a queue that is popped and compared after the edge.
module tb_sistema_de_ventilacao;

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] sc, s1, s2, s3, sr, ss, rea;
   logic alarm, d12, d23, d3ss, d3sr, dsssc, drsr;
   logic [6:0] dout;
   logic [6:0] expq[$];
   int errors = 0;
   int checks = 0;
   int m_st, m_v, m_c;

   always #5 clk = ~clk;

   sistema_de_ventilacao dut (
      .clk(clk),
      .rst_n(rst_n),
      .sensPresSC(sc),
      .sensPresS1(s1),
      .sensPresS2(s2),
      .sensPresS3(s3),
      .sensPresTubSR(sr),
      .sensPresTubSS(ss),
      .sensPresRea(rea),
      .alarmeSonoroVentilacao(alarm),
      .damperS12(d12),
      .damperS23(d23),
      .damperS3SS(d3ss),
      .damperS3SR(d3sr),
      .damperSSSC(dsssc),
      .damperRSR(drsr)
   );

   assign dout = {alarm, d12, d23, d3ss, d3sr, dsssc, drsr};

   task automatic chk(input string tag, input logic [6:0] got,
                      input logic [6:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // model: 0 normal, 1 suspect, 2 alarm, 3 emergency
   task automatic predict(output logic [6:0] e);
      bit good;
      good = (sc > s1) && (s1 > s2) && (s2 > s3) && (s3 > rea) && (rea > sr);
      if (rea >= 4'hC) begin
         m_st = 3;
      end else if (m_st == 0) begin
         if (!good) begin m_st = 1; m_v = 1; end
      end else if (m_st == 1) begin
         if (good) begin
            m_st = 0; m_v = 0;
         end else begin
            if (m_v < 4) m_v++;
            if (m_v == 4) begin m_st = 2; m_c = 0; end
         end
      end else if (m_st == 2) begin
         if (!good) m_c = 0;
         else if (m_c < 8) m_c++;
         if (m_c == 8) begin m_st = 0; m_c = 0; m_v = 0; end
      end else begin
         m_st = 2; m_c = 0;
      end
      if (m_st == 3) e = 7'b1000101;
      else e = {m_st == 2, s1 > s2, s2 > s3, ss > s3,
                s3 > sr, ss > sc, rea > sr};
   endtask

   task automatic tick(input string tag);
      logic [6:0] e;
      predict(e);
      expq.push_back(e);
      @(posedge clk);
      #1;
      chk(tag, dout, expq.pop_front());
   endtask

   task automatic nominal();
      sc = 4'hF; s1 = 4'hC; s2 = 4'h9; s3 = 4'h6;
      rea = 4'h4; sr = 4'h2; ss = 4'hF;
   endtask

   task automatic model_reset();
      m_st = 0; m_v = 0; m_c = 0;
      expq.delete();
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      nominal();
      #12;
      chk("reset", dout, 7'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick("release");
      chk("release_vec", dout, 7'b0111101);

      s2 = 4'hD;
      for (int i = 0; i < 3; i++) tick("transient");
      s2 = 4'h9;
      tick("transient_restore");
      chk("transient_alarm", {6'b0, alarm}, 7'b0);

      s2 = 4'hD;
      for (int i = 0; i < 3; i++) tick("persist_pre");
      tick("persist_edge");
      chk("persist_alarm_s23", {5'b0, alarm, d23}, 7'b0000011);
      for (int i = 0; i < 5; i++) tick("persist_hold");
      s2 = 4'h9;
      for (int i = 0; i < 7; i++) tick("clear_wait");
      chk("clear_7", {6'b0, alarm}, 7'b1);
      tick("clear_8");
      chk("clear_done", {6'b0, alarm}, 7'b0);

      rea = 4'hC;
      tick("emerg");
      chk("emerg_vec", dout, 7'b1000101);
      rea = 4'hF;
      tick("emerg_hold");
      rea = 4'h4;
      tick("emerg_exit");
      chk("emerg_exit_alarm", {6'b0, alarm}, 7'b1);
      for (int i = 0; i < 7; i++) tick("emerg_clear");
      chk("emerg_clear_7", {6'b0, alarm}, 7'b1);
      tick("emerg_clear_8");
      chk("emerg_clear_done", {6'b0, alarm}, 7'b0);

      s1 = 4'h7; s2 = 4'h7; s3 = 4'h1; sr = 4'h3;
      tick("backflow");
      chk("backflow_s12_s3sr", {5'b0, d12, d3sr}, 7'b0);
      for (int i = 0; i < 3; i++) tick("backflow_persist");
      chk("backflow_alarm", {6'b0, alarm}, 7'b1);

      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset", dout, 7'b0);
      model_reset();
      nominal();
      @(negedge clk);
      rst_n = 1'b1;
      tick("post_reset");

      for (int i = 0; i < 60; i++) begin
         s2 = ($urandom_range(0, 3) == 0) ? 4'hD : 4'h9;
         s1 = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'hC;
         rea = ($urandom_range(0, 9) == 0) ? 4'hC : 4'h4;
         ss = 4'(($urandom_range(0, 1) == 0) ? 4'hF : 4'h3);
         tick("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
